// File: rtl/debug_slave_pkg.sv
// Shared definitions for the debug slave command synchronizer.
//   SR_W_DEF / IR_W_DEF / SYNC_STAGES_DEF : default parameter values
//   state_t                               : command FSM state encoding
package debug_slave_pkg;
  localparam int SR_W_DEF        = 38;
  localparam int IR_W_DEF        = 2;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;
endpackage

// File: rtl/debug_slave_cmd_sync_if.sv
// Command handshake between the debug slave and its consumers.
//   jdo            : captured debug data (slave -> consumer)
//   take_action    : per-channel valid, action command
//   take_no_action : per-channel valid, no-action command
//   cmd_ready      : per-channel consumer ready (consumer -> slave)
interface debug_slave_cmd_sync_if
  import debug_slave_pkg::*;
#(
  parameter int SR_W = SR_W_DEF,
  parameter int IR_W = IR_W_DEF
);
  localparam int NCH = 1 << IR_W;

  logic [SR_W-1:0] jdo;
  logic [NCH-1:0]  take_action;
  logic [NCH-1:0]  take_no_action;
  logic [NCH-1:0]  cmd_ready;

  modport slave  (output jdo, output take_action, output take_no_action, input  cmd_ready);
  modport master (input  jdo, input  take_action, input  take_no_action, output cmd_ready);
endinterface

// File: rtl/debug_sync_edge.sv
// Brings a TCK-domain level into clk and emits a one-cycle pulse on its
// rising edge.
//   clk, reset_n : system clock, async active-low reset
//   strobe       : asynchronous level
//   pulse        : registered one-cycle pulse per rising edge
// A strobe that is already high when reset releases is not treated as an
// edge: the detector arms only after it has seen a genuine low sample.
module debug_sync_edge
  import debug_slave_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF  // legal 2..4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic strobe,
  output logic pulse
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;   // marks when sync_q holds real samples
  logic                   prev_q;
  logic                   armed_q;
  logic                   pulse_q;
  logic                   lvl;

  assign lvl   = sync_q[SYNC_STAGES-1];
  assign pulse = pulse_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      fill_q  <= '0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], strobe};
      fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      prev_q  <= lvl;
      armed_q <= armed_q | (fill_q[SYNC_STAGES-1] & ~lvl);
      pulse_q <= lvl & ~prev_q & armed_q;
    end
  end
endmodule

// File: rtl/debug_slave_cmd_sync.sv
// Debug slave command synchronizer: captures JTAG instruction/data strobes
// from the TCK domain and issues them as held per-channel commands in clk.
//   clk, reset_n    : system clock, async active-low reset
//   vs_uir, vs_e1dr : TCK-domain update-IR / exit1-DR levels
//   ir_in, sr       : instruction and shift register (stable while strobed)
//   clr_status      : clears overrun and drop_cnt
//   cmd_if          : jdo / take_action / take_no_action / cmd_ready
//   busy            : command pending
//   overrun         : sticky, a command was dropped
//   drop_cnt        : saturating count of dropped commands
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | no command pending, waiting for exit1-DR pulse
// ST_ISSUE | command valid on cmd_ch, waiting for its ready
module debug_slave_cmd_sync
  import debug_slave_pkg::*;
#(
  parameter int SR_W        = SR_W_DEF,
  parameter int IR_W        = IR_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int ACT_BIT     = SR_W - 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  vs_uir,
  input  logic                  vs_e1dr,
  input  logic [IR_W-1:0]       ir_in,
  input  logic [SR_W-1:0]       sr,
  input  logic                  clr_status,
  debug_slave_cmd_sync_if.slave cmd_if,
  output logic                  busy,
  output logic                  overrun,
  output logic [7:0]            drop_cnt
);
  localparam int NCH = 1 << IR_W;

  state_t          state_q;
  logic [IR_W-1:0] ir_q;
  logic [IR_W-1:0] cmd_ch_q;
  logic [SR_W-1:0] jdo_q;
  logic [NCH-1:0]  ta_q;
  logic [NCH-1:0]  tna_q;
  logic            busy_q;
  logic            overrun_q, overrun_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;
  logic            uir_p, e1dr_p;
  logic            done, drop;
  logic [NCH-1:0]  ch_sel;

  debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uir (
    .clk    (clk),
    .reset_n(reset_n),
    .strobe (vs_uir),
    .pulse  (uir_p)
  );

  debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_e1dr (
    .clk    (clk),
    .reset_n(reset_n),
    .strobe (vs_e1dr),
    .pulse  (e1dr_p)
  );

  // A pulse arriving while a command is pending (including its completion
  // edge) is dropped.
  assign done   = (state_q == ST_ISSUE) && cmd_if.cmd_ready[cmd_ch_q];
  assign drop   = (state_q == ST_ISSUE) && e1dr_p;
  assign ch_sel = NCH'(1) << ir_q;

  // A drop coincident with clr_status counts as the first drop after clear.
  always_comb begin
    overrun_d  = clr_status ? 1'b0 : overrun_q;
    drop_cnt_d = clr_status ? 8'd0 : drop_cnt_q;
    if (drop) begin
      overrun_d = 1'b1;
      if (drop_cnt_d != 8'hFF) drop_cnt_d = drop_cnt_d + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      ir_q       <= '0;
      cmd_ch_q   <= '0;
      jdo_q      <= '0;
      ta_q       <= '0;
      tna_q      <= '0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      // Issue below samples the old ir_q when both pulses coincide.
      if (uir_p) ir_q <= ir_in;
      overrun_q  <= overrun_d;
      drop_cnt_q <= drop_cnt_d;
      case (state_q)
        ST_IDLE: begin
          if (e1dr_p) begin
            state_q  <= ST_ISSUE;
            jdo_q    <= sr;
            cmd_ch_q <= ir_q;
            busy_q   <= 1'b1;
            ta_q     <= sr[ACT_BIT] ? '0 : ch_sel;
            tna_q    <= sr[ACT_BIT] ? ch_sel : '0;
          end
        end
        ST_ISSUE: begin
          if (done) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            ta_q    <= '0;
            tna_q   <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_if.jdo            = jdo_q;
  assign cmd_if.take_action    = ta_q;
  assign cmd_if.take_no_action = tna_q;
  assign busy                  = busy_q;
  assign overrun               = overrun_q;
  assign drop_cnt              = drop_cnt_q;
endmodule

// File: doc/debug_slave_cmd_sync.md
DEBUG_SLAVE_CMD_SYNC -- requirements
Module: debug_slave_cmd_sync

Interface
REQ-001 SHALL have parameter SR_W, default 38: width of the debug shift register and of jdo.
REQ-002 SHALL have parameter IR_W, default 2: instruction width; NCH = 2**IR_W command channels.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, legal 2..4: synchronizer depth for the TCK-domain strobes.
REQ-004 SHALL have parameter ACT_BIT, default SR_W-1: jdo bit that selects action (0) or no-action (1).
REQ-005 SHALL have one clock and an asynchronous, active-low reset, named as the codebase does: clk and reset_n.
REQ-006 clk  in  1  system clock.
REQ-007 reset_n  in  1  async active-low reset.
REQ-008 vs_uir  in  1  TCK-domain update-IR level, asynchronous to clk.
REQ-009 vs_e1dr  in  1  TCK-domain exit1-DR level, asynchronous to clk.
REQ-010 ir_in  in  IR_W  instruction; stable while vs_uir is high.
REQ-011 sr  in  SR_W  shift register; stable while vs_e1dr is high.
REQ-012 cmd_ready  in  NCH  per-channel consumer ready.
REQ-013 clr_status  in  1  synchronous clear of overrun and drop_cnt.
REQ-014 jdo  out  SR_W  captured debug data.
REQ-015 take_action  out  NCH  per-channel valid, action command.
REQ-016 take_no_action  out  NCH  per-channel valid, no-action command.
REQ-017 busy  out  1  command pending.
REQ-018 overrun  out  1  sticky: a command was dropped.
REQ-019 drop_cnt  out  8  saturating count of dropped commands.

Function
REQ-020 Each strobe SHALL pass SYNC_STAGES flops plus one edge flop; a rising edge yields a one-cycle internal pulse (uir_p, e1dr_p).
REQ-021 On uir_p, ir_q SHALL load ir_in.
REQ-022 FSM states: IDLE, ISSUE.
REQ-023 IDLE with e1dr_p: load jdo from sr, load cmd_ch from ir_q, go to ISSUE.
REQ-024 In ISSUE, take_action[cmd_ch] SHALL be high when jdo[ACT_BIT]=0, otherwise take_no_action[cmd_ch]; all other bits 0.
REQ-025 ISSUE SHALL hold the output, jdo and cmd_ch stable until cmd_ready[cmd_ch]=1 at a clk edge, then return to IDLE; ready on other channels SHALL be ignored.
REQ-026 The issued valid bit SHALL first assert SYNC_STAGES+2 clk edges after the first edge that samples vs_e1dr high.
REQ-027 busy SHALL be 1 exactly in ISSUE.
REQ-028 e1dr_p in ISSUE SHALL be dropped: jdo is unchanged, overrun is set, and drop_cnt increments and saturates at 255.
REQ-029 e1dr_p on the same edge the command completes SHALL be dropped as well; completion takes priority.
REQ-030 uir_p and e1dr_p on the same cycle: the command SHALL use the previous ir_q, and ir_q then updates.
REQ-031 uir_p in ISSUE SHALL update ir_q only; the pending cmd_ch SHALL be unaffected.
REQ-032 clr_status SHALL clear overrun and drop_cnt next edge; a coincident drop SHALL win: overrun=1, drop_cnt=1.
REQ-033 vs_e1dr held high SHALL produce exactly one command.

Reset
REQ-034 reset_n low SHALL asynchronously clear all of the following: the sync flops, edge flops, ir_q, cmd_ch, jdo, take_action, take_no_action, busy, overrun and drop_cnt.
REQ-035 reset_n low SHALL force state to IDLE.
REQ-036 Reset during ISSUE SHALL discard the pending command without asserting any further valid bit.
REQ-037 Release of reset_n SHALL be synchronized externally; a strobe already high at release SHALL NOT produce a pulse until it falls and rises again.

Structure
REQ-038 Shared package debug_slave_pkg SHALL hold the FSM state enum and the default values of SR_W, IR_W and SYNC_STAGES.
REQ-039 Sub-module debug_sync_edge (synchronizer plus rising-edge pulse, parameter SYNC_STAGES) SHALL be instantiated once each for vs_uir and vs_e1dr.

Verification
REQ-040 IR_W=2, SR_W=38: ir_in=2, uir; sr=0x0_1234_5678 (bit37=0), e1dr; cmd_ready=4'b0100 -> take_action=4'b0100 on edge 4 after sampling; jdo=0x12345678; busy for 1 cycle.
REQ-041 sr bit37=1, cmd_ready low for 10 cycles -> take_no_action[ch] high and jdo stable for 10 cycles; clears one cycle after ready.
REQ-042 Pending command, 3 extra e1dr pulses -> overrun=1, drop_cnt=3, jdo unchanged; clr_status -> 0/0.
REQ-043 300 dropped pulses -> drop_cnt=255.
REQ-044 Pending on ch1, uir with ir_in=3, cmd_ready=4'b1000 -> no completion; cmd_ready=4'b0010 -> completes; next e1dr issues on ch3.
REQ-045 reset_n low during ISSUE -> all outputs 0 immediately, state IDLE; vs_e1dr held high through release -> no command.
